slice_run_ctrl: RTL and testbench
=================================

SLICE_RUN_CTRL -- requirements
Module: slice_run_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); legal range 1 to 2^20.
REQ-002 Parameter MAX_SLICE, default 16, slice count at which the run finishes; legal range 1 to 31.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 key_start_n  input  1  raw start push-button, active-low, asynchronous to clk.
REQ-006 key_pause_n  input  1  raw pause push-button, active-low, asynchronous to clk.
REQ-007 slice_done_i  input  1  single-cycle pulse from the cutting datapath; one slice completed.
REQ-008 start_o  output  1  single-cycle pulse; run begins; feeds the display decoder's start input.
REQ-009 pause_o  output  1  single-cycle pulse; toggles pause; feeds the display decoder's pause input.
REQ-010 finish_o  output  1  single-cycle pulse; run complete; feeds the display decoder's finish input.
REQ-011 slice_num_o  output  5  slices completed so far, 0 to MAX_SLICE.
REQ-012 run_o  output  1  level; high only in RUN; enables the cutting datapath.

Function
REQ-013 Each key input SHALL pass through a 2-flop synchronizer whose flops reset to 1.
REQ-014 A key press event SHALL be a 1-to-0 transition of the filtered key level, detected against a registered copy of that level.
REQ-015 FSM states SHALL be IDLE, RUN, HOLD and DONE.
REQ-016 IDLE->RUN on a start event; start_o high for exactly the cycle after the event; start events in RUN, HOLD or DONE SHALL be ignored with no pulse.
REQ-017 RUN->HOLD and HOLD->RUN on a pause event, with pause_o high for exactly one cycle; pause events in IDLE or DONE SHALL be ignored with no pulse.
REQ-018 slice_done_i SHALL increment slice_num_o by 1 only in RUN; it is ignored in IDLE, HOLD and DONE.
REQ-019 When an increment in RUN makes slice_num_o equal MAX_SLICE, the FSM SHALL enter DONE and finish_o SHALL be high for exactly the following cycle.
REQ-020 If a pause event coincides with the final slice_done_i, finish SHALL win: the FSM enters DONE and pause_o stays low.
REQ-021 If a pause event coincides with a non-final slice_done_i in RUN, the count SHALL increment and the FSM SHALL enter HOLD.
REQ-022 slice_num_o SHALL saturate at MAX_SLICE and never wrap.
REQ-023 DONE SHALL be exited only by reset.
REQ-024 start_o, pause_o and finish_o SHALL each be registered outputs, never asserted together, and high for at most one consecutive cycle per event.
REQ-025 run_o SHALL be registered and high exactly while the state is RUN.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, slice_num_o=0, start_o=pause_o=finish_o=run_o=0, filtered key levels=1 and debounce counters=0, including mid-run or mid-debounce.
REQ-027 A key still held low when rst_n is released SHALL NOT generate an event until it has been released and pressed again.

Configuration
REQ-028 Macro SLICE_RUN_CTRL_DEBOUNCE_EN SHALL control key filtering.
- Defined: per key, a counter counts cycles while the synchronized level differs from the filtered level and clears when they agree. When the count reaches DB_CYCLES, the filtered level takes the synchronized value and the counter clears.
- Undefined: the filtered level is the synchronizer output; DB_CYCLES is unused.
REQ-029 Event-to-pulse latency SHALL be 4 clk edges from the first rising edge sampling a held-low key without the macro, and DB_CYCLES+4 edges with it.

Verification (bench: DB_CYCLES=4, MAX_SLICE=3; debounce macro defined unless stated)
REQ-030 Hold key_start_n low for 12 cycles -> one start_o pulse at edge 8; run_o=1 from the next cycle; no further pulses.
REQ-031 Toggle key_pause_n low-high-low every cycle for 3 cycles, then hold low -> no event during the bounce; one pause_o pulse once stable; state HOLD; run_o=0.
REQ-032 In HOLD, pulse slice_done_i 2 times -> slice_num_o stays 0; press pause -> RUN; pulse slice_done_i 3 times -> slice_num_o 1,2,3; one finish_o pulse; run_o=0.
REQ-033 With slice_num_o=2, pause event and slice_done_i in the same cycle -> slice_num_o=3, finish_o pulse, pause_o stays 0, state DONE; later start/pause presses -> no pulses.
REQ-034 Macro undefined: key_start_n held low -> start_o at edge 4. Assert rst_n mid-RUN with slice_num_o=1 -> all outputs 0 at once, IDLE; key still held through reset release -> no start_o.

Source files
------------

// File: rtl/slice_run_ctrl_if.sv
// Key, slice and display-strobe signals of slice_run_ctrl.
// The testbench or key/datapath glue drives this through master; the controller uses slave.
interface slice_run_ctrl_if;
    logic       key_start_n;
    logic       key_pause_n;
    logic       slice_done_i;
    logic       start_o;
    logic       pause_o;
    logic       finish_o;
    logic [4:0] slice_num_o;
    logic       run_o;

    modport master (
        output key_start_n, key_pause_n, slice_done_i,
        input  start_o, pause_o, finish_o, slice_num_o, run_o
    );

    modport slave (
        input  key_start_n, key_pause_n, slice_done_i,
        output start_o, pause_o, finish_o, slice_num_o, run_o
    );
endinterface

// File: rtl/slice_run_ctrl.sv
// Slicer run controller: synchronized and optionally debounced start/pause keys drive an
// IDLE/RUN/HOLD/DONE sequencer that counts slices. Key debouncing is enabled by SLICE_RUN_CTRL_DEBOUNCE_EN.
module slice_run_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int MAX_SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    slice_run_ctrl_if.slave  bus
);
    if (DB_CYCLES < 1 || DB_CYCLES > (1 << 20) || MAX_SLICE < 1 || MAX_SLICE > 31) begin : g_bad_param
        $error("slice_run_ctrl: DB_CYCLES or MAX_SLICE out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    localparam int         NKEY      = 2;
    localparam logic [4:0] MAX_COUNT = 5'(MAX_SLICE);

    // Bit 0 is the start key, bit 1 the pause key.
    logic [NKEY-1:0] w_key_raw;
    logic [NKEY-1:0] r_sync1, r_sync2;
    logic [NKEY-1:0] w_level;
    logic [NKEY-1:0] r_prev, r_evt, r_armed;
    logic [1:0]      r_fill;
    logic            w_fill_done;

    assign w_key_raw   = {bus.key_pause_n, bus.key_start_n};
    assign w_fill_done = (r_fill == 2'd2);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SLICE_RUN_CTRL_DEBOUNCE_EN
    localparam int                DB_CW   = $clog2(DB_CYCLES + 1);
    localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DB_CYCLES - 1);

    logic [DB_CW-1:0] r_db_cnt [NKEY];
    logic [NKEY-1:0]  r_level;

    // NOTE: the counter array is small and must restart from zero, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NKEY; k++) r_db_cnt[k] <= '0;
            r_level <= '1;
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                if (r_sync2[k] == r_level[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_level[k]  <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DB_CW'(1);
                end
            end
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    // A key becomes armed only after it has been seen released once the synchronizer has
    // flushed its reset value, so a key held through reset cannot fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= '1;
            r_evt   <= '0;
            r_armed <= '0;
            r_fill  <= '0;
        end else begin
            r_prev  <= w_level;
            r_evt   <= r_armed & r_prev & ~w_level;
            r_armed <= r_armed | (r_sync2 & w_level & {NKEY{w_fill_done}});
            if (!w_fill_done) r_fill <= r_fill + 2'd1;
        end
    end

    state_t     r_state, w_state_nxt;
    logic [4:0] r_slice_num, w_slice_nxt, w_slice_inc;
    logic       r_start, r_pause, r_finish, r_run;
    logic       w_start_nxt, w_pause_nxt, w_finish_nxt;
    logic       w_start_evt, w_pause_evt;

    assign w_start_evt = r_evt[0];
    assign w_pause_evt = r_evt[1];
    assign w_slice_inc = r_slice_num + 5'd1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_slice_nxt  = r_slice_num;
        w_start_nxt  = 1'b0;
        w_pause_nxt  = 1'b0;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_evt) begin
                    w_state_nxt = S_RUN;
                    w_start_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.slice_done_i && r_slice_num < MAX_COUNT) w_slice_nxt = w_slice_inc;
                // The final slice outranks a simultaneous pause.
                if (bus.slice_done_i && w_slice_inc == MAX_COUNT) begin
                    w_state_nxt  = S_DONE;
                    w_finish_nxt = 1'b1;
                end else if (w_pause_evt) begin
                    w_state_nxt = S_HOLD;
                    w_pause_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_pause_evt) begin
                    w_state_nxt = S_RUN;
                    w_pause_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_slice_num <= '0;
            r_start     <= 1'b0;
            r_pause     <= 1'b0;
            r_finish    <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slice_num <= w_slice_nxt;
            r_start     <= w_start_nxt;
            r_pause     <= w_pause_nxt;
            r_finish    <= w_finish_nxt;
            r_run       <= (w_state_nxt == S_RUN);
        end
    end

    assign bus.start_o     = r_start;
    assign bus.pause_o     = r_pause;
    assign bus.finish_o    = r_finish;
    assign bus.slice_num_o = r_slice_num;
    assign bus.run_o       = r_run;
endmodule

// File: tb/tb_slice_run_ctrl.sv
// Directed testbench for slice_run_ctrl with DB_CYCLES=4, MAX_SLICE=3; key latencies follow
// whether SLICE_RUN_CTRL_DEBOUNCE_EN is defined for the build.
module tb_slice_run_ctrl;
    localparam int DB  = 4;
    localparam int MAX = 3;
`ifdef SLICE_RUN_CTRL_DEBOUNCE_EN
    localparam int LAT   = DB + 4;
    localparam bit DEB   = 1'b1;
    localparam int PEDGE = 3 + DB + 3;  // bounce settles low at edge 3
`else
    localparam int LAT   = 4;
    localparam bit DEB   = 1'b0;
    localparam int PEDGE = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    slice_run_ctrl_if bus ();

    slice_run_ctrl #(.DB_CYCLES(DB), .MAX_SLICE(MAX)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; each strobe must be high only at its given edge index (0 = never).
    task automatic watch(input int n, input int st_e, input int pa_e, input int fi_e, input string tag);
        for (int i = 1; i <= n; i++) begin
            tick();
            check({tag, "/start"},  32'(bus.start_o),  32'(i == st_e));
            check({tag, "/pause"},  32'(bus.pause_o),  32'(i == pa_e));
            check({tag, "/finish"}, 32'(bus.finish_o), 32'(i == fi_e));
        end
    endtask

    task automatic pulse_done(input logic [4:0] exp_num, input string tag);
        bus.slice_done_i = 1'b1;
        tick();
        bus.slice_done_i = 1'b0;
        check(tag, 32'(bus.slice_num_o), 32'(exp_num));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "/start"},  32'(bus.start_o),     32'd0);
        check({tag, "/pause"},  32'(bus.pause_o),     32'd0);
        check({tag, "/finish"}, 32'(bus.finish_o),    32'd0);
        check({tag, "/run"},    32'(bus.run_o),       32'd0);
        check({tag, "/num"},    32'(bus.slice_num_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        repeat (4) tick();
        check_idle_outputs("after_reset");
    endtask

    initial begin
        bus.key_start_n  = 1'b1;
        bus.key_pause_n  = 1'b1;
        bus.slice_done_i = 1'b0;
        do_reset();

        // IDLE ignores slices and pause presses
        pulse_done(5'd0, "idle_done");
        bus.key_pause_n = 1'b0;
        watch(LAT + 2, 0, 0, 0, "idle_pause");
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "idle_pause_rel");

        // start held 12 cycles: exactly one pulse at edge LAT
        bus.key_start_n = 1'b0;
        watch(12, LAT, 0, 0, "start_hold");
        check("start_run", 32'(bus.run_o), 32'd1);
        bus.key_start_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "start_rel");

        // pause with bounce (low-high-low) when debouncing, clean press otherwise
        for (int i = 1; i <= 16; i++) begin
            bus.key_pause_n = DEB && (i == 2);
            tick();
            check("bounce/pause", 32'(bus.pause_o),  32'(i == PEDGE));
            check("bounce/start", 32'(bus.start_o),  32'd0);
            check("bounce/fin",   32'(bus.finish_o), 32'd0);
        end
        check("hold_run", 32'(bus.run_o), 32'd0);
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "pause_rel");

        // HOLD ignores slices, pause resumes
        pulse_done(5'd0, "hold_done1");
        pulse_done(5'd0, "hold_done2");
        bus.key_pause_n = 1'b0;
        watch(LAT + 1, 0, LAT, 0, "resume");
        check("resume_run", 32'(bus.run_o), 32'd1);
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "resume_rel");

        pulse_done(5'd1, "run_done1");
        pulse_done(5'd2, "run_done2");
        bus.slice_done_i = 1'b1;
        tick();
        bus.slice_done_i = 1'b0;
        check("final_num", 32'(bus.slice_num_o), 32'd3);
        check("final_fin", 32'(bus.finish_o),    32'd1);
        check("final_run", 32'(bus.run_o),       32'd0);
        tick();
        check("final_fin_drop", 32'(bus.finish_o), 32'd0);
        pulse_done(5'd3, "done_saturate");

        // second run: pause coinciding with non-final then final slice
        do_reset();
        bus.key_start_n = 1'b0;
        watch(LAT + 1, LAT, 0, 0, "start2");
        bus.key_start_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "start2_rel");
        pulse_done(5'd1, "run2_done1");

        bus.key_pause_n = 1'b0;
        watch(LAT - 1, 0, 0, 0, "co_nonfinal_wait");
        bus.slice_done_i = 1'b1;
        tick();
        bus.slice_done_i = 1'b0;
        check("co_nf_num",   32'(bus.slice_num_o), 32'd2);
        check("co_nf_pause", 32'(bus.pause_o),     32'd1);
        check("co_nf_fin",   32'(bus.finish_o),    32'd0);
        check("co_nf_run",   32'(bus.run_o),       32'd0);
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "co_nf_rel");

        bus.key_pause_n = 1'b0;
        watch(LAT + 1, 0, LAT, 0, "resume2");
        check("resume2_run", 32'(bus.run_o), 32'd1);
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "resume2_rel");

        bus.key_pause_n = 1'b0;
        watch(LAT - 1, 0, 0, 0, "co_final_wait");
        bus.slice_done_i = 1'b1;
        tick();
        bus.slice_done_i = 1'b0;
        check("co_f_num",   32'(bus.slice_num_o), 32'd3);
        check("co_f_fin",   32'(bus.finish_o),    32'd1);
        check("co_f_pause", 32'(bus.pause_o),     32'd0);
        check("co_f_run",   32'(bus.run_o),       32'd0);
        watch(LAT + 2, 0, 0, 0, "co_f_after");
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "co_f_rel");

        // DONE ignores both keys
        bus.key_start_n = 1'b0;
        bus.key_pause_n = 1'b0;
        watch(LAT + 4, 0, 0, 0, "done_keys");
        check("done_num", 32'(bus.slice_num_o), 32'd3);
        check("done_run", 32'(bus.run_o),       32'd0);
        bus.key_start_n = 1'b1;
        bus.key_pause_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "done_keys_rel");

        // asynchronous reset mid-run with start key held through release
        do_reset();
        bus.key_start_n = 1'b0;
        watch(LAT + 1, LAT, 0, 0, "start3");
        pulse_done(5'd1, "run3_done1");
        check("run3_run", 32'(bus.run_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (3) tick();
        rst_n = 1'b1;
        watch(LAT + 6, 0, 0, 0, "held_through_reset");
        check("held_run", 32'(bus.run_o), 32'd0);
        bus.key_start_n = 1'b1;
        watch(LAT + 2, 0, 0, 0, "held_rel");
        bus.key_start_n = 1'b0;
        watch(LAT + 1, LAT, 0, 0, "repress");
        check("repress_run", 32'(bus.run_o), 32'd1);
        bus.key_start_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
